serial_word_source: RTL and testbench
=====================================

// Module: serial_word_source
// PURPOSE
//   Parallel-to-serial stage feeding the serial bit input of the run detector FSM.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk.
//   A one-word holding buffer lets consecutive words stream with no idle gap.
//   Between words the line sits at IDLE_BIT.
// PARAMETERS
//   WIDTH      8   bits per word, >= 2
//   MSB_FIRST  1   1: din[WIDTH-1] sent first; 0: din[0] sent first
//   IDLE_BIT   0   value driven on x while no word is shifting
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   din        in   WIDTH  parallel word to serialise
//   din_valid  in   1      din holds a word; source keeps din stable until accepted
//   din_ready  out  1      block can take a word this cycle
//   x          out  1      serial bit to detector input
//   x_valid    out  1      x carries a word bit this cycle
//   word_done  out  1      x carries the last bit of the current word
//   busy       out  1      a word is shifting or buffered
// BEHAVIOUR
//   Reset: while rst=1, all outputs take their reset values immediately.
//   - Reset values: x=IDLE_BIT, x_valid=0, word_done=0, busy=0, din_ready=1.
//   - State=IDLE, cnt=0, holding buffer empty.
//   State: shift reg SR[WIDTH], counter cnt[$clog2(WIDTH)], holding reg HB, flag hb_full.
//   States: IDLE, SHIFT.
//   din_ready = !hb_full. This includes IDLE and the cycle of the last bit.
//   Accept = din_valid && din_ready at a rising clk edge.
//   IDLE:
//   - Accept -> SR<=din, cnt<=0, go to SHIFT.
//   - Latency: first bit is on x in the cycle right after the accepting edge.
//   - Otherwise stay in IDLE.
//   SHIFT:
//   - x = SR bit selected by cnt; x_valid=1; word_done = (cnt==WIDTH-1).
//   - Order is set by MSB_FIRST.
//   - Edge with cnt<WIDTH-1: cnt<=cnt+1. An Accept here writes HB and sets hb_full.
//   - Edge with cnt==WIDTH-1, first matching case wins:
//     1. hb_full: SR<=HB, hb_full<=0, cnt<=0, stay in SHIFT.
//     2. Accept (HB empty): SR<=din directly (bypass), cnt<=0, stay in SHIFT.
//     3. Otherwise: go to IDLE, cnt<=0.
//   - Cases 1 and 2 give zero bubble between words.
//   - Case 1 cannot coincide with an Accept, since din_ready=0 while hb_full.
//   busy = (state==SHIFT) || hb_full.
//   Outside SHIFT: x=IDLE_BIT, x_valid=0, word_done=0.
//   din_valid without din_ready: no effect. The source must hold din.
//   Reset mid-word: the partial word and buffered word are discarded.
//   - After reset releases, the next accepted word starts from its first bit.
//   - No partial bits are replayed.
//   All outputs are decoded from registered state; no combinational path din->x.
// TESTING  (WIDTH=8, MSB_FIRST=1, IDLE_BIT=0 unless noted)
//   Reset: pulse rst mid-sim -> x=0, x_valid=0, busy=0, din_ready=1 with no clk edge.
//   Single word: din=8'b1110_0111 accepted at edge N.
//   - x = 1,1,1,0,0,1,1,1 in cycles N+1..N+8.
//   - word_done only in N+8; IDLE at N+9.
//   - Downstream detector y goes high after the third 1.
//   Back-to-back: din_valid held, words 8'hFF then 8'h0F.
//   - 16 contiguous x_valid cycles: 8 ones, then 0000_1111.
//   - din_ready=0 while HB is full.
//   LSB-first (MSB_FIRST=0), din=8'h01 -> x = 1,0,0,0,0,0,0,0; IDLE_BIT=1 -> x=1 when idle.
//   Reset mid-word: rst asserted after 3 bits of 8'hAA.
//   - Outputs go to reset values at once.
//   - Next word 8'hC3 is emitted in full as 1,1,0,0,0,0,1,1.
//   Stall: third word offered while HB is full.
//   - Not accepted until din_ready=1; then emitted intact with no bubble.

Source files
------------

// File: rtl/serial_word_source.sv
// Parallel-to-serial word source: first bit one cycle after accept, one bit per clk.
// One-word holding buffer; din_ready drops only while that buffer is occupied.
module serial_word_source #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_hb;
   logic             r_hb_full;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic [CW-1:0]    w_idx;

   assign w_accept = din_valid && !r_hb_full;
   assign w_last   = (r_cnt == LAST);
   assign w_idx    = MSB_FIRST ? (LAST - r_cnt) : r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sr      <= '0;
         r_hb      <= '0;
         r_hb_full <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_sr    <= din;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!w_last) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_accept) begin
                     r_hb      <= din;
                     r_hb_full <= 1'b1;
                  end
               end else if (r_hb_full) begin
                  // buffered word follows with no bubble; din_ready is low so no accept can race this
                  r_sr      <= r_hb;
                  r_hb_full <= 1'b0;
                  r_cnt     <= '0;
               end else if (w_accept) begin
                  r_sr  <= din;
                  r_cnt <= '0;
               end else begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      x         = IDLE_BIT;
      x_valid   = 1'b0;
      word_done = 1'b0;
      if (r_state == SHIFT) begin
         x         = r_sr[w_idx];
         x_valid   = 1'b1;
         word_done = w_last;
      end
   end

   assign din_ready = !r_hb_full;
   assign busy      = (r_state == SHIFT) || r_hb_full;

endmodule

// File: tb/tb_serial_word_source.sv
// Directed bench for serial_word_source: MSB-first/idle-0 and LSB-first/idle-1 instances, scoreboard per DUT.
module tb_serial_word_source;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din0 = '0, din1 = '0;
   logic       dv0 = 1'b0, dv1 = 1'b0;
   logic       rdy0, x0, xv0, wd0, busy0;
   logic       rdy1, x1, xv1, wd1, busy1;

   int total = 0;
   int bad   = 0;
   logic [1:0] q0[$];
   logic [1:0] q1[$];

   always #5 clk = ~clk;

   serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
      .x(x0), .x_valid(xv0), .word_done(wd0), .busy(busy0));

   serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
      .x(x1), .x_valid(xv1), .word_done(wd1), .busy(busy1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboards: pop one expected {word_done, bit} per valid output cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (xv0) begin
            if (q0.size() == 0) check("d0_unexpected_bit", 1, 0);
            else begin
               logic [1:0] e;
               e = q0.pop_front();
               check("d0_x", x0, e[0]);
               check("d0_word_done", wd0, e[1]);
            end
         end else begin
            check("d0_idle_x", {wd0, x0}, 2'b00);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (xv1) begin
            if (q1.size() == 0) check("d1_unexpected_bit", 1, 0);
            else begin
               logic [1:0] e;
               e = q1.pop_front();
               check("d1_x", x1, e[0]);
               check("d1_word_done", wd1, e[1]);
            end
         end else begin
            check("d1_idle_x", {wd1, x1}, 2'b01);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int which, input logic [7:0] w);
      int budget;
      budget = 0;
      if (which == 0) begin din0 = w; dv0 = 1'b1; end
      else            begin din1 = w; dv1 = 1'b1; end
      while (((which == 0) ? rdy0 : rdy1) !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) check("accept_timeout", 1, 0);
      for (int i = 0; i < 8; i++) begin
         if (which == 0) q0.push_back({(i == 7), w[7-i]});
         else            q1.push_back({(i == 7), w[i]});
      end
      @(posedge clk);
      @(negedge clk);
      if (which == 0) dv0 = 1'b0;
      else            dv1 = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_d0"}, {x0, xv0, wd0, busy0, rdy0}, 5'b00001);
      check({tag, "_d1"}, {x1, xv1, wd1, busy1, rdy1}, 5'b10001);
   endtask

   initial begin
      #1;
      check_reset_outputs("reset_initial");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single word: bits in N+1..N+8, idle at N+9.
      send(0, 8'b1110_0111);
      check("single_busy", busy0, 1'b1);
      repeat (7) @(negedge clk);
      check("single_last_bit_done", {xv0, wd0}, 2'b11);
      @(negedge clk);
      check("single_idle_after", {xv0, busy0, rdy0}, 3'b001);
      check("single_q_empty", q0.size(), 0);

      // Back-to-back FF then 0F with valid held.
      send(0, 8'hFF);
      send(0, 8'h0F);
      check("b2b_ready_low_hb_full", {rdy0, busy0}, 2'b01);
      for (int i = 0; i < 15; i++) begin
         check("b2b_contiguous", xv0, 1'b1);
         if (i == 6) check("b2b_ready_low_until_handoff", rdy0, 1'b0);
         @(negedge clk);
      end
      check("b2b_idle_after", xv0, 1'b0);
      check("b2b_q_empty", q0.size(), 0);

      // Stall: third word waits for the buffer to drain, then streams with no bubble.
      send(0, 8'hA5);
      send(0, 8'h3C);
      send(0, 8'h96);
      check("stall_buffered", rdy0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         check("stall_contiguous", xv0, 1'b1);
         @(negedge clk);
      end
      check("stall_idle_after", {xv0, busy0}, 2'b00);
      check("stall_q_empty", q0.size(), 0);

      // Reset mid-word with a buffered word: everything discarded immediately.
      send(0, 8'hAA);
      send(0, 8'h55);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_mid_word");
      q0.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {xv0, busy0, rdy0}, 3'b001);
      send(0, 8'hC3);
      repeat (8) @(negedge clk);
      check("post_reset_q_empty", q0.size(), 0);

      // LSB-first instance with idle line high.
      check("lsb_idle_high", {x1, xv1}, 2'b10);
      send(1, 8'h01);
      check("lsb_first_bit", {x1, xv1}, 2'b11);
      repeat (8) @(negedge clk);
      check("lsb_idle_after", {x1, xv1, busy1}, 3'b100);
      send(1, 8'h80);
      send(1, 8'h6D);
      repeat (16) @(negedge clk);
      check("lsb_q_empty", q1.size(), 0);
      check("final_q0_empty", q0.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      check("global_timeout", 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "FAIL global_timeout");
   end

endmodule
